// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg
//   Shared definitions for the register-file dump master: FSM state
//   encoding and the default data/address widths. The register file uses
//   the same WIDTH/REGBITS defaults.
package regfile_dump_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_REGBITS = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } dump_state_e;

  // True while a dump occupies the read port and the output stream.
  function automatic logic is_busy(input dump_state_e s);
    return (s == S_FETCH) || (s == S_SEND);
  endfunction

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump
//   Read-side master for the register file. Starting from a pulse on start,
//   walks the address range first_reg..last_reg (modulo 2^REGBITS) through
//   one combinational register-file read port and presents every value as a
//   valid/ready stream word tagged with its address and a last flag.
//   One word per two cycles with out_ready held high.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   start      one-cycle dump request, honoured only in IDLE
//   abort      cancel an in-progress dump (no done pulse)
//   first_reg  first address of the range, sampled on accepted start
//   last_reg   last address of the range, sampled on accepted start
//   rf_ra      register-file read address (registered)
//   rf_rd      register-file read data (combinational from rf_ra)
//   out_valid  stream word valid
//   out_ready  downstream accepts word
//   out_data   register value
//   out_addr   address the value was read from
//   out_last   word is the final one of the dump
//   busy       high in FETCH or SEND
//   done       one-cycle pulse when a dump completes normally
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned REGBITS = DEF_REGBITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [REGBITS-1:0] first_reg,
  input  logic [REGBITS-1:0] last_reg,
  output logic [REGBITS-1:0] rf_ra,
  input  logic [WIDTH-1:0]   rf_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [REGBITS-1:0] out_addr,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  dump_state_e        state_q, state_d;
  logic [REGBITS-1:0] ptr_q,   ptr_d;
  logic [REGBITS-1:0] end_q,   end_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [REGBITS-1:0] addr_q,  addr_d;
  logic               last_q,  last_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    last_d  = last_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          ptr_d   = first_reg;
          end_d   = last_reg;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        data_d  = rf_rd;
        addr_d  = ptr_q;
        last_d  = (ptr_q == end_q);
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + REGBITS'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort takes priority over any handshake or transition in flight.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end

    // busy/done are registered from the next state so they line up with it.
    busy_d = is_busy(state_d);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rf_ra     = ptr_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  localparam int unsigned W = 32;
  localparam int unsigned RB = 5;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [RB-1:0] first_reg;
  logic [RB-1:0] last_reg;
  logic [RB-1:0] rf_ra;
  logic [W-1:0]  rf_rd;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [RB-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [W-1:0] rf [32];
  assign rf_rd = rf[rf_ra];

  int unsigned n_total;
  int unsigned n_pass;

  regfile_dump #(.WIDTH(W), .REGBITS(RB)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg), .rf_ra(rf_ra), .rf_rd(rf_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [RB-1:0] first;
    logic [RB-1:0] last;
    int unsigned   nwords;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [W-1:0] model(input logic [RB-1:0] a);
    return 32'h11 * 32'(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/valid"}, 32'(out_valid), 32'd0);
    chk({tag, "/busy"},  32'(busy),      32'd0);
    chk({tag, "/done"},  32'(done),      32'd0);
  endtask

  // Full dump with out_ready high; called one cycle after a posedge.
  task automatic run_dump(input logic [RB-1:0] f, input logic [RB-1:0] l,
                          input int unsigned n, input string tag);
    logic [RB-1:0] a;
    first_reg = f;
    last_reg  = l;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "/fetch busy"},  32'(busy),      32'd1);
    chk({tag, "/fetch valid"}, 32'(out_valid), 32'd0);
    a = f;
    for (int unsigned k = 0; k < n; k++) begin
      tick();
      chk({tag, "/valid"}, 32'(out_valid), 32'd1);
      chk({tag, "/addr"},  32'(out_addr),  32'(a));
      chk({tag, "/data"},  out_data,       model(a));
      chk({tag, "/last"},  32'(out_last),  32'(k == n - 1));
      tick();
      if (k != n - 1) begin
        chk({tag, "/gap valid"}, 32'(out_valid), 32'd0);
        chk({tag, "/gap busy"},  32'(busy),      32'd1);
      end
      a = a + RB'(1);
    end
    chk({tag, "/done pulse"}, 32'(done),      32'd1);
    chk({tag, "/done busy"},  32'(busy),      32'd0);
    chk({tag, "/done valid"}, 32'(out_valid), 32'd0);
    tick();
    chk_idle({tag, "/after"});
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < 32; i++) rf[i] = model(RB'(i));

    vecs[0] = '{first: 5'd1,  last: 5'd4,  nwords: 4};
    vecs[1] = '{first: 5'd30, last: 5'd1,  nwords: 4};
    vecs[2] = '{first: 5'd7,  last: 5'd7,  nwords: 1};
    vecs[3] = '{first: 5'd0,  last: 5'd31, nwords: 32};
    vecs[4] = '{first: 5'd5,  last: 5'd3,  nwords: 31};
    vecs[5] = '{first: 5'd31, last: 5'd0,  nwords: 2};

    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_reg = '0; last_reg = '0;
    tick();
    tick();
    chk("reset/rf_ra",  32'(rf_ra),     32'd0);
    chk("reset/valid",  32'(out_valid), 32'd0);
    chk("reset/data",   out_data,       32'd0);
    chk("reset/addr",   32'(out_addr),  32'd0);
    chk("reset/last",   32'(out_last),  32'd0);
    chk("reset/busy",   32'(busy),      32'd0);
    chk("reset/done",   32'(done),      32'd0);
    reset = 1'b0;
    tick();
    chk_idle("post-reset");

    for (int i = 0; i < 6; i++)
      run_dump(vecs[i].first, vecs[i].last, vecs[i].nwords, $sformatf("vec%0d", i));

    // Backpressure on addr 2 of range 1..4; rf[2] changes after sampling.
    first_reg = 5'd1; last_reg = 5'd4; start = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("bp/w1 addr", 32'(out_addr), 32'd1);
    tick();
    out_ready = 1'b0;
    tick();
    rf[2] = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      chk("bp/hold valid", 32'(out_valid), 32'd1);
      chk("bp/hold addr",  32'(out_addr),  32'd2);
      chk("bp/hold data",  out_data,       32'h22);
      tick();
    end
    out_ready = 1'b1;
    chk("bp/release addr", 32'(out_addr), 32'd2);
    tick();
    rf[2] = model(5'd2);
    chk("bp/gap valid", 32'(out_valid), 32'd0);
    tick();
    chk("bp/w3 addr", 32'(out_addr), 32'd3);
    chk("bp/w3 data", out_data,      32'h33);
    tick(); tick();
    chk("bp/w4 addr", 32'(out_addr), 32'd4);
    chk("bp/w4 last", 32'(out_last), 32'd1);
    tick();
    chk("bp/done", 32'(done), 32'd1);
    tick();
    chk_idle("bp/after");

    // Single-word range; a start during SEND must be ignored.
    first_reg = 5'd7; last_reg = 5'd7; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("one/addr", 32'(out_addr), 32'd7);
    chk("one/last", 32'(out_last), 32'd1);
    out_ready = 1'b0; start = 1'b1; first_reg = 5'd0; last_reg = 5'd31;
    tick(); start = 1'b0;
    chk("one/still addr",  32'(out_addr),  32'd7);
    chk("one/still valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("one/done", 32'(done), 32'd1);
    tick();
    chk_idle("one/idle");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle("one/no redump");
    end

    // Abort in SEND of the 2nd word of 1..8.
    first_reg = 5'd1; last_reg = 5'd8; start = 1'b1; out_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("abort/w2 addr",  32'(out_addr),  32'd2);
    chk("abort/w2 valid", 32'(out_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort/next");
    tick();
    chk_idle("abort/later");
    run_dump(5'd10, 5'd12, 3, "abort/redump");

    // abort wins over start in IDLE.
    start = 1'b1; abort = 1'b1; first_reg = 5'd1; last_reg = 5'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_idle("abortstart/1");
    tick();
    chk_idle("abortstart/2");

    // Asynchronous reset mid-SEND.
    first_reg = 5'd1; last_reg = 5'd4; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("rst/pre valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst/async valid", 32'(out_valid), 32'd0);
    chk("rst/async data",  out_data,       32'd0);
    chk("rst/async addr",  32'(out_addr),  32'd0);
    chk("rst/async last",  32'(out_last),  32'd0);
    chk("rst/async busy",  32'(busy),      32'd0);
    chk("rst/async rf_ra", 32'(rf_ra),     32'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle("rst/idle");
    end
    run_dump(5'd2, 5'd3, 2, "rst/redump");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
